// File: rtl/cobi_sequencer.sv
// COBI chip-network sequencer: weight writes, anneal, sample, scan-out.
// One registered FSM drives every network control and the spin stream.
module cobi_sequencer #(
  parameter int NUM_CHAINS          = 4,
  parameter int NUM_CHIPS_PER_CHAIN = 1,
  parameter int CYC_W               = 16
) (
  input  logic                          i_CLK,
  input  logic                          i_RST_N,
  input  logic                          i_W_VALID,
  output logic                          o_W_READY,
  input  logic [5:0]                    i_W_ROW,
  input  logic [5:0]                    i_W_COL,
  input  logic [NUM_CHIPS_PER_CHAIN-1:0] i_W_CHIP,
  input  logic [6*NUM_CHAINS-1:0]       i_W_DATA,
  input  logic                          i_START,
  input  logic [CYC_W-1:0]              i_ANNEAL_CYC,
  output logic                          o_BUSY,
  output logic                          o_DONE,
  output logic                          o_SPIN_VALID,
  output logic [NUM_CHAINS-1:0]         o_SPIN_BITS,
  output logic [6+$clog2(NUM_CHIPS_PER_CHAIN+1)-1:0] o_SPIN_IDX,
  output logic [5:0]                    o_ROW_ADDR,
  output logic [5:0]                    o_COL_ADDR,
  output logic [6*NUM_CHAINS-1:0]       o_WEIGHT,
  output logic [NUM_CHIPS_PER_CHAIN-1:0] o_ADDR_EN64,
  output logic                          o_WEIGHT_EN,
  output logic                          o_ROSC_EN,
  output logic                          o_SAMPLE_CLK,
  output logic                          o_SCANOUT_CLK,
  output logic                          o_ALL_ROW_HI,
  input  logic [NUM_CHAINS-1:0]         i_SCANOUT_DOUT64
);

  localparam int L     = 64 * NUM_CHIPS_PER_CHAIN;
  localparam int IDX_W = 6 + $clog2(NUM_CHIPS_PER_CHAIN + 1);
  localparam int WD_W  = 6 * NUM_CHAINS;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(L - 1);

  typedef enum logic [3:0] {
    IDLE, WSETUP, WSTROBE, WHOLD,
    ANNEAL, SAMPLE, SCAN_LO, SCAN_HI, FIN
  } state_e;

  state_e                  state_q;
  logic [CYC_W-1:0]        cnt_q;
  logic [CYC_W-1:0]        anneal_d;
  logic [IDX_W-1:0]        bit_q;
  logic                    ready_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    sval_q;
  logic [NUM_CHAINS-1:0]   sbits_q;
  logic [5:0]              row_q;
  logic [5:0]              col_q;
  logic [WD_W-1:0]         wdat_q;
  logic [NUM_CHIPS_PER_CHAIN-1:0] aen_q;
  logic                    wen_q;
  logic                    rosc_q;
  logic                    samp_q;
  logic                    sclk_q;

  // A zero anneal request still runs the oscillators for one cycle.
  assign anneal_d = (i_ANNEAL_CYC == '0) ? CYC_W'(1) : i_ANNEAL_CYC;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sval_q  <= 1'b0;
      sbits_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      wdat_q  <= '0;
      aen_q   <= '0;
      wen_q   <= 1'b0;
      rosc_q  <= 1'b0;
      samp_q  <= 1'b0;
      sclk_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_W_VALID) begin
            row_q   <= i_W_ROW;
            col_q   <= i_W_COL;
            wdat_q  <= i_W_DATA;
            aen_q   <= i_W_CHIP;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= WSETUP;
          end else if (i_START) begin
            cnt_q   <= anneal_d;
            rosc_q  <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ANNEAL;
          end
        end
        WSETUP: begin
          wen_q   <= 1'b1;
          state_q <= WSTROBE;
        end
        WSTROBE: begin
          wen_q   <= 1'b0;
          state_q <= WHOLD;
        end
        WHOLD: begin
          aen_q   <= '0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        ANNEAL: begin
          if (cnt_q == CYC_W'(1)) begin
            cnt_q   <= '0;
            samp_q  <= 1'b1;
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q - CYC_W'(1);
          end
        end
        // samp_q doubles as the first-half marker of the 2-cycle sample.
        SAMPLE: begin
          if (samp_q) begin
            samp_q <= 1'b0;
          end else begin
            rosc_q  <= 1'b0;
            state_q <= SCAN_LO;
          end
        end
        SCAN_LO: begin
          sbits_q <= i_SCANOUT_DOUT64;
          sval_q  <= 1'b1;
          sclk_q  <= 1'b1;
          state_q <= SCAN_HI;
        end
        SCAN_HI: begin
          sval_q <= 1'b0;
          sclk_q <= 1'b0;
          if (bit_q == LAST) begin
            bit_q   <= '0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            bit_q   <= bit_q + IDX_W'(1);
            state_q <= SCAN_LO;
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_W_READY     = ready_q;
  assign o_BUSY        = busy_q;
  assign o_DONE        = done_q;
  assign o_SPIN_VALID  = sval_q;
  assign o_SPIN_BITS   = sbits_q;
  assign o_SPIN_IDX    = bit_q;
  assign o_ROW_ADDR    = row_q;
  assign o_COL_ADDR    = col_q;
  assign o_WEIGHT      = wdat_q;
  assign o_ADDR_EN64   = aen_q;
  assign o_WEIGHT_EN   = wen_q;
  assign o_ROSC_EN     = rosc_q;
  assign o_SAMPLE_CLK  = samp_q;
  assign o_SCANOUT_CLK = sclk_q;
  assign o_ALL_ROW_HI  = 1'b0;

endmodule

// File: tb/tb_cobi_sequencer.sv
// Bench for cobi_sequencer: timeline model of writes and runs,
// a shifting scan-chain model, and directed scenarios.
module tb_cobi_sequencer;

  localparam int NCH = 4;
  localparam int L   = 64;

  logic        i_CLK;
  logic        i_RST_N;
  logic        w_valid;
  logic        w_ready;
  logic [5:0]  w_row;
  logic [5:0]  w_col;
  logic [0:0]  w_chip;
  logic [23:0] w_data;
  logic        start;
  logic [15:0] cyc;
  logic        o_BUSY;
  logic        o_DONE;
  logic        o_SPIN_VALID;
  logic [3:0]  o_SPIN_BITS;
  logic [6:0]  o_SPIN_IDX;
  logic [5:0]  o_ROW_ADDR;
  logic [5:0]  o_COL_ADDR;
  logic [23:0] o_WEIGHT;
  logic [0:0]  o_ADDR_EN64;
  logic        o_WEIGHT_EN;
  logic        o_ROSC_EN;
  logic        o_SAMPLE_CLK;
  logic        o_SCANOUT_CLK;
  logic        o_ALL_ROW_HI;
  logic [3:0]  dout;

  cobi_sequencer dut (
    .i_CLK            (i_CLK),
    .i_RST_N          (i_RST_N),
    .i_W_VALID        (w_valid),
    .o_W_READY        (w_ready),
    .i_W_ROW          (w_row),
    .i_W_COL          (w_col),
    .i_W_CHIP         (w_chip),
    .i_W_DATA         (w_data),
    .i_START          (start),
    .i_ANNEAL_CYC     (cyc),
    .o_BUSY           (o_BUSY),
    .o_DONE           (o_DONE),
    .o_SPIN_VALID     (o_SPIN_VALID),
    .o_SPIN_BITS      (o_SPIN_BITS),
    .o_SPIN_IDX       (o_SPIN_IDX),
    .o_ROW_ADDR       (o_ROW_ADDR),
    .o_COL_ADDR       (o_COL_ADDR),
    .o_WEIGHT         (o_WEIGHT),
    .o_ADDR_EN64      (o_ADDR_EN64),
    .o_WEIGHT_EN      (o_WEIGHT_EN),
    .o_ROSC_EN        (o_ROSC_EN),
    .o_SAMPLE_CLK     (o_SAMPLE_CLK),
    .o_SCANOUT_CLK    (o_SCANOUT_CLK),
    .o_ALL_ROW_HI     (o_ALL_ROW_HI),
    .i_SCANOUT_DOUT64 (dout)
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  // Chain model: each scan clock shifts the next stored bit out.
  logic [63:0] pat [NCH];
  int sc_cnt;
  always @(posedge o_SCANOUT_CLK or negedge i_RST_N) begin
    if (!i_RST_N) sc_cnt <= 0;
    else          sc_cnt <= (sc_cnt + 1) % L;
  end
  always_comb begin
    dout = '0;
    for (int c = 0; c < NCH; c++) dout[c] = pat[c][sc_cnt];
  end

  // Model: mode 0 idle, 1 write, 2 run; t = cycle number since acceptance.
  int mode = 0;
  int t = 0;
  int n = 1;
  int edges = 0;
  int acc_edge = 0;
  int wacc_edge = 0;
  logic [5:0]  m_row = '0;
  logic [5:0]  m_col = '0;
  logic [0:0]  m_chip = '0;
  logic [23:0] m_data = '0;

  always @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      mode = 0; t = 0;
      m_row = '0; m_col = '0; m_data = '0; m_chip = '0;
    end else begin
      edges++;
      if (mode == 0) begin
        if (w_valid) begin
          mode = 1; t = 1; wacc_edge = edges;
          m_row = w_row; m_col = w_col;
          m_chip = w_chip; m_data = w_data;
        end else if (start) begin
          mode = 2; t = 1; acc_edge = edges;
          n = (cyc == 0) ? 1 : int'(cyc);
        end
      end else if ((mode == 1 && t == 3) ||
                   (mode == 2 && t == n + 2*L + 3)) begin
        mode = 0; t = 0;
      end else begin
        t++;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int rosc_n = 0, samp_n = 0, sclk_n = 0, valid_n = 0;
  int done_n = 0, wen_n = 0, nrdy_n = 0;
  int done_edge = 0, wen_edge = 0;
  logic [3:0] bits5 = '0;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic compare();
    int st, k;
    logic hi;
    logic [3:0] eb;
    st = t - n - 3;
    k  = st / 2;
    hi = (mode == 2) && (t >= n + 3) && (t <= n + 2 + 2*L)
         && (st % 2 == 1);
    chk("ready", w_ready, mode == 0);
    chk("busy", o_BUSY, mode != 0);
    chk("weight_en", o_WEIGHT_EN, mode == 1 && t == 2);
    chk("addr_en", o_ADDR_EN64, (mode == 1) ? m_chip : 1'b0);
    chk("row", o_ROW_ADDR, m_row);
    chk("col", o_COL_ADDR, m_col);
    chk("weight", o_WEIGHT, m_data);
    chk("rosc", o_ROSC_EN, mode == 2 && t <= n + 2);
    chk("sample", o_SAMPLE_CLK, mode == 2 && t == n + 1);
    chk("scan_clk", o_SCANOUT_CLK, hi);
    chk("spin_valid", o_SPIN_VALID, hi);
    chk("done", o_DONE, mode == 2 && t == n + 2*L + 3);
    chk("all_row_hi", o_ALL_ROW_HI, 1'b0);
    if (hi) begin
      for (int c = 0; c < NCH; c++) eb[c] = pat[c][k];
      chk("spin_bits", o_SPIN_BITS, eb);
      chk("spin_idx", o_SPIN_IDX, k);
    end
    if (mode == 0) chk("idx_idle", o_SPIN_IDX, 0);
  endtask

  task automatic tick();
    @(negedge i_CLK);
    compare();
    if (o_ROSC_EN) rosc_n++;
    if (o_SAMPLE_CLK) samp_n++;
    if (o_SCANOUT_CLK) sclk_n++;
    if (o_SPIN_VALID) valid_n++;
    if (o_WEIGHT_EN) begin wen_n++; wen_edge = edges; end
    if (!w_ready) nrdy_n++;
    if (o_DONE) begin done_n++; done_edge = edges; end
    if (o_SPIN_VALID && o_SPIN_IDX == 7'd5) bits5 = o_SPIN_BITS;
  endtask

  task automatic wait_done(input string nm);
    int d0;
    d0 = done_n;
    for (int i = 0; i < 400 && done_n == d0; i++) tick();
    chk(nm, done_n - d0, 1);
  endtask

  task automatic do_run(input logic [15:0] c, input int e_rosc,
                        input int e_cyc);
    int r0, s0, k0, v0, d0;
    r0 = rosc_n; s0 = samp_n; k0 = sclk_n;
    v0 = valid_n; d0 = done_n;
    cyc = c; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 16'hFFFF;
    wait_done("run_done_seen");
    repeat (3) tick();
    chk("rosc_cycles", rosc_n - r0, e_rosc);
    chk("sample_pulses", samp_n - s0, 1);
    chk("scan_pulses", sclk_n - k0, 64);
    chk("spin_valids", valid_n - v0, 64);
    chk("done_pulses", done_n - d0, 1);
    chk("done_cycle", done_edge - acc_edge + 1, e_cyc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int d0, v0, w0, n0;
    logic found;
    i_RST_N = 1'b0;
    w_valid = 1'b0; w_row = '0; w_col = '0;
    w_chip = '0; w_data = '0; start = 1'b0; cyc = '0;
    pat[0] = 64'hFFFF_FFFF_0000_0000;
    pat[1] = 64'hAAAA_AAAA_AAAA_AAAA;
    pat[2] = 64'h0000_0000_0000_0020;
    pat[3] = 64'h5555_5555_5555_5555;
    repeat (3) tick();
    chk("rst_ready", w_ready, 1'b1);
    chk("rst_busy", o_BUSY, 1'b0);
    i_RST_N = 1'b1;
    repeat (2) tick();

    // Weight write
    w0 = wen_n; n0 = nrdy_n;
    w_valid = 1'b1; w_row = 6'd5; w_col = 6'd9;
    w_chip = 1'b1; w_data = 24'hAAAAAA;
    tick();
    w_valid = 1'b0; w_row = 6'd0; w_col = 6'd0; w_data = '0;
    chk("wsetup_row", o_ROW_ADDR, 6'd5);
    chk("wsetup_col", o_COL_ADDR, 6'd9);
    chk("wsetup_data", o_WEIGHT, 24'hAAAAAA);
    chk("wsetup_aen", o_ADDR_EN64, 1'b1);
    repeat (5) tick();
    chk("wen_cycles", wen_n - w0, 1);
    chk("wen_cycle", wen_edge - wacc_edge + 1, 2);
    chk("ready_low_cycles", nrdy_n - n0, 3);

    // Anneal 10, known pattern
    do_run(16'd10, 12, 141);
    chk("bits_idx5", bits5, 4'h6);

    // Zero anneal is one cycle
    pat[0] = 64'h0123_4567_89AB_CDEF;
    do_run(16'd0, 3, 132);

    // Write and start together: write wins, run follows
    cyc = 16'd3;
    w_valid = 1'b1; start = 1'b1;
    w_row = 6'd7; w_col = 6'd33; w_data = 24'h123456;
    tick();
    w_valid = 1'b0;
    for (int i = 0; i < 20 && !o_ROSC_EN; i++) tick();
    start = 1'b0;
    chk("run_after_write", acc_edge - wacc_edge, 4);
    wait_done("wr_run_done_seen");
    chk("wr_run_cycle", done_edge - acc_edge + 1, 134);
    repeat (2) tick();

    // Start/write while scanning are ignored
    d0 = done_n;
    cyc = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50 && !o_SCANOUT_CLK; i++) tick();
    start = 1'b1; w_valid = 1'b1; w_row = 6'd60;
    repeat (6) tick();
    start = 1'b0; w_valid = 1'b0;
    repeat (200) tick();
    chk("one_done", done_n - d0, 1);

    // Reset at scan bit 20
    cyc = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      found = o_SPIN_VALID && (o_SPIN_IDX == 7'd20);
    end
    chk("reach_bit20", found, 1'b1);
    d0 = done_n; v0 = valid_n;
    #2 i_RST_N = 1'b0;
    #1;
    chk("arst_ready", w_ready, 1'b1);
    chk("arst_busy", o_BUSY, 1'b0);
    chk("arst_rosc", o_ROSC_EN, 1'b0);
    chk("arst_valid", o_SPIN_VALID, 1'b0);
    chk("arst_idx", o_SPIN_IDX, 7'd0);
    chk("arst_weight", o_WEIGHT, 24'd0);
    repeat (3) tick();
    i_RST_N = 1'b1;
    repeat (150) tick();
    chk("abort_no_done", done_n - d0, 0);
    chk("abort_no_valid", valid_n - v0, 0);
    do_run(16'd4, 6, 135);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cobi_sequencer.md
COBI_SEQUENCER -- requirements
Module: cobi_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_CHAINS, 4, number of parallel chip chains.
- NUM_CHIPS_PER_CHAIN, 1, chips daisy-chained per chain.
- CYC_W, 16, width of the anneal-cycle count.
REQ-002 Ports SHALL be (name, direction, width, meaning), clock and reset first:
- i_CLK, in, 1: the single clock.
- i_RST_N, in, 1: reset, asynchronous, active-low.
- i_W_VALID, in, 1: weight write request.
- o_W_READY, out, 1: weight write accepted.
- i_W_ROW, in, 6: write row address.
- i_W_COL, in, 6: write column address.
- i_W_CHIP, in, NUM_CHIPS_PER_CHAIN: one-hot chip select.
- i_W_DATA, in, 6*NUM_CHAINS: per-chain weight.
- i_START, in, 1: run request.
- i_ANNEAL_CYC, in, CYC_W: oscillator-enable duration.
- o_BUSY, out, 1: FSM not IDLE.
- o_DONE, out, 1: one-cycle pulse at scan completion.
- o_SPIN_VALID, out, 1: spin bit valid.
- o_SPIN_BITS, out, NUM_CHAINS: one scanned bit per chain.
- o_SPIN_IDX, out, 6+clog2(NUM_CHIPS_PER_CHAIN+1): bit index.
- o_ROW_ADDR, o_COL_ADDR, out, 6: network addresses.
- o_WEIGHT, out, 6*NUM_CHAINS: network weight bus.
- o_ADDR_EN64, out, NUM_CHIPS_PER_CHAIN: chip address enables.
- o_WEIGHT_EN, o_ROSC_EN, o_SAMPLE_CLK, o_SCANOUT_CLK, o_ALL_ROW_HI, out, 1: network controls.
- i_SCANOUT_DOUT64, in, NUM_CHAINS: chain scan outputs.

Function
REQ-003 FSM states SHALL be IDLE, WSETUP, WSTROBE, WHOLD, ANNEAL, SAMPLE, SCAN_LO, SCAN_HI, FIN.
REQ-004 o_W_READY SHALL be 1 only in IDLE; a write is accepted when i_W_VALID&&o_W_READY.
REQ-005 On an accepted write, the block SHALL register row, col, chip and data onto o_ROW_ADDR, o_COL_ADDR, o_ADDR_EN64 and o_WEIGHT, then go IDLE->WSETUP->WSTROBE->WHOLD->IDLE.
- o_WEIGHT_EN=1 only in WSTROBE.
- Address, data and enables are held stable through WHOLD.
- One write therefore takes 4 cycles, including the IDLE acceptance cycle.
REQ-006 o_ADDR_EN64 SHALL be driven to 0 on the cycle after WHOLD.
REQ-007 In IDLE, i_W_VALID SHALL take priority over i_START when both are asserted; i_START is level-sampled and is acted on only in IDLE with i_W_VALID=0.
REQ-008 On start, the block SHALL latch i_ANNEAL_CYC into a down-counter and enter ANNEAL with o_ROSC_EN=1.
- ANNEAL lasts exactly max(i_ANNEAL_CYC,1) cycles.
- i_ANNEAL_CYC=0 is treated as 1.
REQ-009 SAMPLE SHALL last 2 cycles with o_ROSC_EN=1: o_SAMPLE_CLK=1 in the first cycle and 0 in the second; o_ROSC_EN drops to 0 on entry to SCAN_LO.
REQ-010 Scan SHALL produce L=64*NUM_CHIPS_PER_CHAIN bits, each one SCAN_LO cycle followed by one SCAN_HI cycle; o_SCANOUT_CLK=1 only in SCAN_HI.
REQ-011 In each SCAN_LO, the block SHALL capture i_SCANOUT_DOUT64 into o_SPIN_BITS and assert o_SPIN_VALID for one cycle on the next clock, with o_SPIN_IDX = bit number 0..L-1.
REQ-012 o_ALL_ROW_HI SHALL be 0 throughout.
REQ-013 After bit L-1's SCAN_HI, the block SHALL enter FIN: o_DONE=1 for one cycle, then IDLE; the index counter wraps to 0.
REQ-014 o_BUSY SHALL be 1 in every state except IDLE.
REQ-015 i_START and i_W_VALID asserted while busy SHALL be ignored: no queuing, and no change to latched parameters.
REQ-016 Total run latency from the start-acceptance edge to o_DONE SHALL be N+2+2L+1 cycles, where N=max(i_ANNEAL_CYC,1).

Reset
REQ-017 On i_RST_N low, the block SHALL immediately force:
- state IDLE;
- all counters 0;
- all outputs 0, except o_W_READY=1.
REQ-018 A reset mid-write or mid-scan SHALL abort with no o_DONE and no further o_SPIN_VALID; the first edge after release behaves as IDLE.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Write: row=5, col=9, chip=1, data=0x2A per chain -> o_WEIGHT_EN high exactly 1 cycle (2 edges after acceptance); addr/data stable from WSETUP through WHOLD; o_W_READY low 3 cycles.
- Run with i_ANNEAL_CYC=10, NUM_CHIPS_PER_CHAIN=1, chains driven with a known 64-bit pattern per chain -> ROSC_EN high 12 cycles; one SAMPLE_CLK pulse; 64 SCANOUT_CLK pulses; 64 SPIN_VALID with idx 0..63 matching the pattern; o_DONE at cycle 141.
- i_ANNEAL_CYC=0 -> ANNEAL lasts 1 cycle; run completes normally.
- i_W_VALID and i_START asserted together in IDLE -> write is performed first; run starts after return to IDLE if i_START is still high.
- i_START pulsed during SCAN -> ignored; exactly one o_DONE.
- i_RST_N asserted at scan bit 20 -> all outputs 0 asynchronously; no o_DONE; next run starts cleanly from idx 0.
